// File: rtl/datapath_if.sv
// datapath_if: start/operand request and product/done response of the Booth multiplier
interface datapath_if #(parameter int N = 8);
  logic           start;
  logic [N-1:0]   a_in;
  logic [N-1:0]   b_in;
  logic [2*N-1:0] result;
  logic           done;
  modport master (output start, a_in, b_in, input result, done);
  modport slave (input start, a_in, b_in, output result, done);
endinterface

// File: rtl/datapath.sv
// datapath: sequential radix-2 Booth signed multiplier, one Booth step per clock, N steps per product
module datapath_reg #(parameter int W = 8) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] inp_out
);
  always_ff @(posedge clk)
    if (!reset) inp_out <= '0;
    else if (i_en) inp_out <= i_d;
endmodule

module datapath_cnt #(parameter int W = 4) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_ld,
  input  logic         i_dec,
  input  logic [W-1:0] i_n,
  output logic [W-1:0] Counter_out
);
  always_ff @(posedge clk)
    if (!reset) Counter_out <= '0;
    else if (i_ld) Counter_out <= i_n;
    else if (i_dec) Counter_out <= Counter_out - W'(1);
endmodule

module datapath #(parameter int N = 8) (
  input  logic       clk,
  input  logic       reset,
  datapath_if.slave  bus
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t        r_state;
  logic [N:0]    r_acc;
  logic          r_q1;
  logic [N-1:0]  w_m, w_q, w_q_nx, w_q_d;
  logic [CW-1:0] w_cnt;
  logic [N:0]    w_m_ext, w_sum, w_acc_nx;
  logic          w_ld, w_run;
  assign w_ld  = (r_state == IDLE) && bus.start;
  assign w_run = (r_state == RUN);
  // M sign-extended to N+1 bits so that subtracting -2^(N-1) cannot overflow A
  assign w_m_ext  = {w_m[N-1], w_m};
  assign w_sum    = ({w_q[0], r_q1} == 2'b01) ? r_acc + w_m_ext :
                    ({w_q[0], r_q1} == 2'b10) ? r_acc - w_m_ext : r_acc;
  assign w_acc_nx = {w_sum[N], w_sum[N:1]};
  assign w_q_nx   = {w_sum[0], w_q[N-1:1]};
  assign w_q_d    = w_ld ? bus.b_in : w_q_nx;
  datapath_reg #(.W(N)) reg_a (
    .clk(clk), .reset(reset), .i_en(w_ld), .i_d(bus.a_in), .inp_out(w_m)
  );
  datapath_reg #(.W(N)) reg_b (
    .clk(clk), .reset(reset), .i_en(w_ld || w_run), .i_d(w_q_d), .inp_out(w_q)
  );
  datapath_cnt #(.W(CW)) Counter1 (
    .clk(clk), .reset(reset), .i_ld(w_ld), .i_dec(w_run), .i_n(CW'(N)), .Counter_out(w_cnt)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_q1       <= 1'b0;
      bus.result <= '0;
      bus.done   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (w_ld) begin
        r_state <= RUN;
        r_acc   <= '0;
        r_q1    <= 1'b0;
      end else if (w_run) begin
        r_acc <= w_acc_nx;
        r_q1  <= w_q[0];
        if (w_cnt == CW'(1)) begin
          bus.result <= {w_acc_nx[N-1:0], w_q_nx};
          bus.done   <= 1'b1;
          r_state    <= IDLE;
        end
      end
    end
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: random and directed checks of the Booth multiplier against a product-level reference model
module tb_datapath;
  localparam int N = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic chk_en = 1'b0;
  int errs = 0;
  int checks = 0;
  datapath_if #(.N(N)) bus ();
  datapath #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [3:0] cnt;
  assign cnt = dut.Counter1.Counter_out;
  always #5 clk = ~clk;

  // Model: a latched product appears N edges after the load edge; nothing else about the algorithm
  bit                     m_busy = 0;
  int                     m_left = 0;
  logic signed [2*N-1:0]  m_prod = '0;
  logic [2*N-1:0]         m_res = '0;
  logic                   m_done = 0;
  always @(posedge clk) begin
    m_done = 0;
    if (!reset) begin
      m_busy = 0; m_left = 0; m_res = '0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_busy = 1;
        m_left = N;
        m_prod = $signed(bus.a_in) * $signed(bus.b_in);
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_res = m_prod; m_done = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (chk_en) begin
      chk("model_done", 64'(bus.done), 64'(m_done));
      chk("model_result", 64'(bus.result), 64'(m_res));
      chk("model_count", 64'(cnt), 64'(m_left));
    end

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2*N-1:0] exp, input string nm);
    int n;
    @(negedge clk);
    bus.start = 1; bus.a_in = a; bus.b_in = b;
    @(negedge clk);
    bus.start = 0;
    chk({nm, "_cnt_load"}, 64'(cnt), 64'(N));
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
      if (n <= N) chk({nm, "_cnt_step"}, 64'(cnt), 64'(N - n));
    end
    chk({nm, "_done"}, 64'(bus.done), 64'd1);
    chk({nm, "_result"}, 64'(bus.result), 64'(exp));
    @(negedge clk);
    chk({nm, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  function automatic logic [N-1:0] pick();
    logic [N-1:0] e [4] = '{8'h80, 8'h7f, 8'h00, 8'hff};
    return ($urandom % 4 == 0) ? e[$urandom % 4] : N'($urandom);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.start = 1; bus.a_in = 8'h11; bus.b_in = 8'h22;
    repeat (2) @(negedge clk);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_count", 64'(cnt), 64'd0);
    chk("rst_rega", 64'(dut.reg_a.inp_out), 64'd0);
    bus.start = 0;
    reset = 1;
    chk_en = 1;
    run_op(8'd127, 8'h80, 16'hC080, "p127xm128");
    run_op(8'h80, 8'h80, 16'h4000, "m128xm128");
    run_op(8'h80, 8'd127, 16'hC080, "m128x127");
    run_op(8'd7, 8'hFD, 16'hFFEB, "7xm3");
    run_op(8'd0, 8'hFF, 16'h0000, "0xm1");
    run_op(8'hFF, 8'hFF, 16'h0001, "m1xm1");
    // back-to-back with operands changed during RUN
    @(negedge clk);
    bus.start = 1; bus.a_in = 8'd5; bus.b_in = 8'hFA;
    @(negedge clk);
    bus.a_in = 8'd3; bus.b_in = 8'd4;
    n = 0;
    while (!bus.done && n < 20) begin @(negedge clk); n++; end
    chk("b2b_first", 64'(bus.result), 64'hFFE2);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.done && n < 20);
    chk("b2b_period", 64'(n), 64'(N + 1));
    chk("b2b_second", 64'(bus.result), 64'd12);
    bus.start = 0;
    repeat (12) @(negedge clk);
    // abort at step 4
    @(negedge clk);
    bus.start = 1; bus.a_in = 8'd100; bus.b_in = 8'hB3;
    @(negedge clk);
    bus.start = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("abort_result", 64'(bus.result), 64'd0);
    chk("abort_count", 64'(cnt), 64'd0);
    chk("abort_rega", 64'(dut.reg_a.inp_out), 64'd0);
    chk("abort_regb", 64'(dut.reg_b.inp_out), 64'd0);
    reset = 1;
    run_op(8'd100, 8'hB3, 16'hE1EC, "after_abort");
    // random traffic, occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset = ($urandom % 300) != 0;
      bus.start = ($urandom % 3) != 0;
      bus.a_in = pick();
      bus.b_in = pick();
    end
    @(negedge clk);
    reset = 1; bus.start = 0;
    repeat (12) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/datapath.md
# datapath

Sequential signed (two's-complement) multiplier datapath using radix-2 Booth recoding. It takes two N-bit signed operands and produces a 2N-bit signed product after N iteration cycles, one Booth step per clock. It contains its own small control FSM, operand registers, iteration counter and add/subtract/shift unit. It is the core of the single-purpose multiplier processor.

## Interface
- N, default 8: operand width in bits (N ≥ 2); product width is 2N.

Ports:
- clk  in  1  rising-edge clock; all state changes on this edge.
- reset  in  1  synchronous, active-low; sampled on the rising clk edge; 0 clears all state.
- start  in  1  level request; sampled only in IDLE.
- a_in  in  N  signed multiplicand.
- b_in  in  N  signed multiplier.
- result  out  2N  signed product register; holds the last completed product.
- done  out  1  one-cycle pulse when result has just been updated.

Required internal instance names, probed hierarchically by benches:
- Counter1: iteration counter, output Counter_out.
- reg_a: multiplicand register M, output inp_out.
- reg_b: multiplier register, output inp_out.

## Operation
- States: IDLE, RUN.
- Reset (reset=0 at an edge): state=IDLE; result=0; done=0; accumulator, multiplier register, Q₋₁, reg_a and Counter_out all 0.
- IDLE with start=1 at an edge: reg_a←a_in; reg_b←b_in (the Q register); accumulator A←0; Q₋₁←0; Counter_out←N; go to RUN. With start=0, stay in IDLE and hold all values.
- RUN, each edge (one Booth step):
  - {Q[0],Q₋₁}=01: A←A+M.
  - {Q[0],Q₋₁}=10: A←A−M.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,Q₋₁} by 1; Counter_out←Counter_out−1.
- A is N+1 bits. M is sign-extended to N+1 bits before the add or subtract. This keeps M=−2^(N−1) exact, with no overflow.
- On the RUN edge where Counter_out goes 1→0:
  - result←{A[N−1:0],Q} after the final shift, which is the exact 2N-bit signed product.
  - done←1; state←IDLE.
- done is 0 on every other edge.
- a_in and b_in changes during RUN are ignored, because the operands were latched at load.
- start held high continuously: a new operation is loaded in the IDLE cycle right after completion, so operations repeat back-to-back.
- result changes only at completion or reset.

## Timing
- Edge L (IDLE, start=1): load; Counter_out=N visible after L.
- Edges L+1 … L+N: Booth steps. result and done become valid after edge L+N, so latency is N+1 edges from the start-sampling edge.
- done stays high for exactly one cycle (between edges L+N and L+N+1).
- Back-to-back throughput with start held: one product every N+1 cycles.
- reset=0 mid-RUN: the operation is aborted at that edge. All state, including result, returns to reset values.
- reset has priority over start.

## Test plan
- Reset: hold reset=0 for 2 edges → result=0, done=0, Counter_out=0, state IDLE; start=1 during reset is ignored.
- N=8, a_in=127, b_in=8'h80 (−128), start=1 → after 9 edges result=16'hC080 (−16256), done pulses 1 cycle; Counter_out steps 8,7,…,0.
- a_in=−128, b_in=−128 → result=16'h4000 (16384). Also −128×127 → −16256.
- a_in=7, b_in=−3 → 16'hFFEB (−21). a_in=0, b_in=−1 → 0. a_in=−1, b_in=−1 → 1.
- start held high with inputs changed mid-RUN → current result is unaffected by the change; the next operation loads the new values immediately after done, period 9 cycles.
- Assert reset=0 at step 4 of an operation → all state is cleared. A subsequent start produces the correct fresh product.
